// File: rtl/cpu_core_pkg.sv
//------------------------------------------------------------------------------
// cpu_core_pkg : opcodes, control states and flag bit positions of cpu_core
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_core_pkg;

  localparam int ADDR_W    = 6;
  localparam int MEM_DEPTH = 64;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_NOT = 8'h06;
  localparam logic [7:0] OP_SHL = 8'h07;
  localparam logic [7:0] OP_SHR = 8'h08;
  localparam logic [7:0] OP_INC = 8'h09;
  localparam logic [7:0] OP_DEC = 8'h0A;
  localparam logic [7:0] OP_CMP = 8'h0B;
  localparam logic [7:0] OP_HLT = 8'hFF;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
//------------------------------------------------------------------------------
// cpu_alu : combinational 8-bit ALU producing result, flags and write enables
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_alu
  import cpu_core_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [7:0] i_op,
  output logic [7:0] o_r,
  output logic [7:0] o_flags,
  output logic       o_wr_c,
  output logic       o_wr_f
);

  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [4:0] w_nsum;
  logic       w_cf;
  logic       w_af;

  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b};
    w_diff = {1'b0, i_a} - {1'b0, i_b};
    w_nsum = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]};
    o_r    = 8'h00;
    w_cf   = 1'b0;
    w_af   = 1'b0;
    o_wr_c = 1'b1;
    o_wr_f = 1'b1;
    case (i_op)
      OP_ADD: begin
        o_r  = w_sum[7:0];
        w_cf = w_sum[8];
        w_af = w_nsum[4];
      end
      OP_SUB, OP_CMP: begin
        o_r    = w_diff[7:0];
        w_cf   = w_diff[8];
        w_af   = (i_a[3:0] < i_b[3:0]);
        o_wr_c = (i_op == OP_SUB);
      end
      OP_AND: o_r = i_a & i_b;
      OP_OR:  o_r = i_a | i_b;
      OP_XOR: o_r = i_a ^ i_b;
      OP_NOT: o_r = ~i_a;
      OP_SHL: begin
        o_r  = {i_a[6:0], 1'b0};
        w_cf = i_a[7];
      end
      OP_SHR: begin
        o_r  = {1'b0, i_a[7:1]};
        w_cf = i_a[0];
      end
      OP_INC: begin
        o_r  = i_a + 8'd1;
        w_cf = (i_a == 8'hFF);
        w_af = (i_a[3:0] == 4'hF);
      end
      OP_DEC: begin
        o_r  = i_a - 8'd1;
        w_cf = (i_a == 8'h00);
        w_af = (i_a[3:0] == 4'h0);
      end
      OP_NOP: begin
        o_wr_c = 1'b0;
        o_wr_f = 1'b0;
      end
      // HLT and undefined opcodes leave C and flags alone
      default: begin
        o_wr_c = 1'b0;
        o_wr_f = 1'b0;
      end
    endcase

    o_flags          = 8'h00;
    o_flags[FLAG_CF] = w_cf;
    o_flags[FLAG_PF] = ~^o_r;
    o_flags[FLAG_AF] = w_af;
    o_flags[FLAG_ZF] = (o_r == 8'h00);
    o_flags[FLAG_SF] = o_r[7];
  end

endmodule

`default_nettype wire

// File: rtl/cpu_core.sv
//------------------------------------------------------------------------------
// cpu_core : 64-byte program memory, PC, 4-cycle control FSM and registers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_core
  import cpu_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Data_w,
  input  logic       ram_we,
  output logic [7:0] alu_out,
  output logic [7:0] flags
);

  logic [7:0]        r_mem [0:MEM_DEPTH-1];
  logic [ADDR_W-1:0] r_pc;
  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_ir;
  logic [7:0]        r_op1;
  logic [7:0]        r_op2;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [7:0]        r_c;
  logic [7:0]        r_flags;
  logic [7:0]        w_r;
  logic [7:0]        w_flags;
  logic              w_wr_c;
  logic              w_wr_f;

  // Program memory is deliberately outside the reset domain so it survives rst
  always_ff @(posedge clk) begin
    if (ram_we) r_mem[r_pc] <= Data_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ram_we) begin
      w_next = (r_state == ST_HALT) ? ST_HALT : ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: w_next = ST_LOAD;
        ST_LOAD:  w_next = ST_EXEC;
        ST_EXEC:  w_next = (r_ir == OP_HLT) ? ST_HALT : ST_NEXT;
        ST_NEXT:  w_next = ST_FETCH;
        ST_HALT:  w_next = ST_HALT;
        default:  w_next = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_ir    <= 8'h00;
      r_op1   <= 8'h00;
      r_op2   <= 8'h00;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_c     <= 8'h00;
      r_flags <= 8'h00;
    end else if (ram_we) begin
      r_pc <= r_pc + ADDR_W'(1);
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir  <= r_mem[r_pc];
          r_op1 <= r_mem[r_pc + ADDR_W'(1)];
          r_op2 <= r_mem[r_pc + ADDR_W'(2)];
        end
        ST_LOAD: begin
          r_a <= r_op1;
          r_b <= r_op2;
        end
        ST_EXEC: begin
          if (w_wr_c) r_c     <= w_r;
          if (w_wr_f) r_flags <= w_flags;
        end
        ST_NEXT: r_pc <= r_pc + ADDR_W'(3);
        default: ;
      endcase
    end
  end

  cpu_alu u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_ir),
    .o_r     (w_r),
    .o_flags (w_flags),
    .o_wr_c  (w_wr_c),
    .o_wr_f  (w_wr_f)
  );

  assign alu_out = r_c;
  assign flags   = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
//------------------------------------------------------------------------------
// tb_cpu_core : scoreboard bench for cpu_core
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_core;
  import cpu_core_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ram_we;
  logic [7:0] Data_w;
  wire  [7:0] alu_out;
  wire  [7:0] flags;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];
  logic [7:0]  prog [$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk     (clk),
    .rst     (rst),
    .Data_w  (Data_w),
    .ram_we  (ram_we),
    .alu_out (alu_out),
    .flags   (flags)
  );

  // Independent reference: returns {C, flags} after executing one opcode
  function automatic logic [15:0] model(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c_in,
                                        input logic [7:0] f_in);
    int ai = int'(a);
    int bi = int'(b);
    int r = 0;
    int n = 0;
    bit cf = 0, af = 0, pf, upd_c = 1, upd_f = 1;
    logic [7:0] r8, c, f;
    case (op)
      8'h01: begin r = ai + bi; cf = (r > 255); af = ((ai % 16) + (bi % 16)) > 15; end
      8'h02, 8'h0B: begin
        r = ai - bi; cf = (ai < bi); af = (ai % 16) < (bi % 16);
        if (op == 8'h0B) upd_c = 0;
      end
      8'h03: r = ai & bi;
      8'h04: r = ai | bi;
      8'h05: r = ai ^ bi;
      8'h06: r = 255 - ai;
      8'h07: begin r = ai * 2; cf = (ai >= 128); end
      8'h08: begin r = ai / 2; cf = (ai % 2) == 1; end
      8'h09: begin r = ai + 1; cf = (ai == 255); af = (ai % 16) == 15; end
      8'h0A: begin r = ai - 1; cf = (ai == 0); af = (ai % 16) == 0; end
      default: begin upd_c = 0; upd_f = 0; end
    endcase
    r8 = r[7:0];
    for (int i = 0; i < 8; i++) n += int'(r8[i]);
    pf = (n % 2) == 0;
    c = upd_c ? r8 : c_in;
    f = upd_f ? {r8[7], (r8 == 8'h00), 1'b0, af, 1'b0, pf, 1'b0, cf} : f_in;
    return {c, f};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic load_prog;
    pulse_rst();
    ram_we = 1'b1;
    foreach (prog[i]) begin
      Data_w = prog[i];
      tick();
    end
    ram_we = 1'b0;
    pulse_rst();
  endtask

  task automatic test_reset;
    rst = 1'b1; ram_we = 1'b0; Data_w = 8'h00;
    #12;
    checks++;
    if (alu_out !== 8'h00 || flags !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: alu_out=%h flags=%h expected 00 00", alu_out, flags);
    end
    checks++;
    if (dut.r_pc !== 6'd0 || dut.r_state !== ST_FETCH) begin
      errors++;
      $display("FAIL reset_pc_state: pc=%0d state=%0d expected 0 %0d", dut.r_pc, dut.r_state, ST_FETCH);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add;
    prog = '{8'h01, 8'h05, 8'h03};
    load_prog();
    sb.push_back(16'h0800);
    tick(); tick(); tick();
    exp_v = sb.pop_front();
    checks++;
    if (alu_out !== exp_v[15:8] || flags !== exp_v[7:0]) begin
      errors++;
      $display("FAIL add_exec: alu_out=%h flags=%h expected %h %h", alu_out, flags, exp_v[15:8], exp_v[7:0]);
    end
    checks++;
    if (dut.r_pc !== 6'd0) begin
      errors++;
      $display("FAIL add_pc_edge3: pc=%0d expected 0", dut.r_pc);
    end
    tick();
    checks++;
    if (dut.r_pc !== 6'd3 || dut.r_state !== ST_FETCH) begin
      errors++;
      $display("FAIL add_pc_edge4: pc=%0d state=%0d expected 3 %0d", dut.r_pc, dut.r_state, ST_FETCH);
    end
  endtask

  task automatic test_flags;
    logic [7:0] pa [2] = '{8'h01, 8'h02};
    logic [7:0] pb [2] = '{8'hFF, 8'h00};
    logic [15:0] fixed [2] = '{16'h0055, 16'hFF95};
    for (int k = 0; k < 2; k++) begin
      prog = '{pa[k], pb[k], 8'h01};
      load_prog();
      sb.push_back(fixed[k]);
      tick(); tick(); tick();
      exp_v = sb.pop_front();
      checks++;
      if (alu_out !== exp_v[15:8] || flags !== exp_v[7:0]) begin
        errors++;
        $display("FAIL flags_case%0d: alu_out=%h flags=%h expected %h %h", k, alu_out, flags, exp_v[15:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_ops;
    logic [7:0] t_op [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h00, 8'h3C};
    logic [7:0] t_a  [13] = '{8'h80, 8'h10, 8'hAA, 8'hA0, 8'hFF, 8'h55, 8'h81,
                              8'h01, 8'hFF, 8'h00, 8'h03, 8'h12, 8'h11};
    logic [7:0] t_b  [13] = '{8'h80, 8'h01, 8'h0F, 8'h05, 8'h0F, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h07, 8'h34, 8'h22};
    for (int k = 0; k < 13; k++) begin
      prog = '{t_op[k], t_a[k], t_b[k]};
      load_prog();
      sb.push_back(model(t_op[k], t_a[k], t_b[k], 8'h00, 8'h00));
      tick(); tick(); tick();
      exp_v = sb.pop_front();
      checks++;
      if (alu_out !== exp_v[15:8]) begin
        errors++;
        $display("FAIL op_%h_result: alu_out=%h expected %h", t_op[k], alu_out, exp_v[15:8]);
      end
      checks++;
      if (flags !== exp_v[7:0]) begin
        errors++;
        $display("FAIL op_%h_flags: flags=%h expected %h", t_op[k], flags, exp_v[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] c = 8'h00, f = 8'h00;
    prog = '{8'h01, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h05, 8'h07,
             8'h0B, 8'h07, 8'h07, 8'h09, 8'h7F, 8'h00, 8'h08, 8'h03, 8'h00};
    for (int k = 0; k < 6; k++) begin
      exp_v = model(prog[3*k], prog[3*k+1], prog[3*k+2], c, f);
      sb.push_back(exp_v);
      c = exp_v[15:8];
      f = exp_v[7:0];
    end
    load_prog();
    for (int k = 0; k < 6; k++) begin
      tick(); tick(); tick();
      exp_v = sb.pop_front();
      checks++;
      if (alu_out !== exp_v[15:8] || flags !== exp_v[7:0]) begin
        errors++;
        $display("FAIL b2b_instr%0d: alu_out=%h flags=%h expected %h %h", k, alu_out, flags, exp_v[15:8], exp_v[7:0]);
      end
      tick();
      checks++;
      if (dut.r_pc !== 6'(3 * (k + 1))) begin
        errors++;
        $display("FAIL b2b_pc%0d: pc=%0d expected %0d", k, dut.r_pc, 3 * (k + 1));
      end
    end
  endtask

  task automatic test_halt;
    int bad = 0;
    prog = '{8'h03, 8'hF0, 8'h3C, 8'h0B, 8'h05, 8'h05, 8'hFF, 8'h00, 8'h00};
    load_prog();
    sb.push_back(16'h3004);
    sb.push_back(16'h3044);
    for (int k = 0; k < 2; k++) begin
      tick(); tick(); tick();
      exp_v = sb.pop_front();
      checks++;
      if (alu_out !== exp_v[15:8] || flags !== exp_v[7:0]) begin
        errors++;
        $display("FAIL halt_prog_instr%0d: alu_out=%h flags=%h expected %h %h", k, alu_out, flags, exp_v[15:8], exp_v[7:0]);
      end
      tick();
    end
    tick(); tick(); tick();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (dut.r_state !== ST_HALT || dut.r_pc !== 6'd6 || alu_out !== 8'h30 || flags !== 8'h44) begin
        errors++;
        $display("FAIL halt_hold%0d: state=%0d pc=%0d alu_out=%h flags=%h expected %0d 6 30 44",
                 k, dut.r_state, dut.r_pc, alu_out, flags, ST_HALT);
      end
      tick();
    end
    ram_we = 1'b1;
    Data_w = 8'hAA;
    tick();
    ram_we = 1'b0;
    checks++;
    if (dut.r_state !== ST_HALT || dut.r_pc !== 6'd7 || dut.r_mem[6] !== 8'hAA || alu_out !== 8'h30) begin
      errors++;
      $display("FAIL halt_load: state=%0d pc=%0d mem6=%h alu_out=%h expected %0d 7 aa 30",
               dut.r_state, dut.r_pc, dut.r_mem[6], alu_out, ST_HALT);
    end
    bad = 0;
    tick(); tick();
    checks++;
    if (dut.r_state !== ST_HALT) begin
      errors++;
      $display("FAIL halt_after_load: state=%0d expected %0d", dut.r_state, ST_HALT);
    end
  endtask

  task automatic test_reset_exec;
    prog = '{8'h01, 8'h05, 8'h03, 8'h09, 8'h07, 8'h00};
    load_prog();
    tick(); tick(); tick(); tick();
    tick(); tick();
    checks++;
    if (dut.r_state !== ST_EXEC || alu_out !== 8'h08) begin
      errors++;
      $display("FAIL rstexec_pre: state=%0d alu_out=%h expected %0d 08", dut.r_state, alu_out, ST_EXEC);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (alu_out !== 8'h00 || flags !== 8'h00 || dut.r_pc !== 6'd0 || dut.r_state !== ST_FETCH) begin
      errors++;
      $display("FAIL rstexec_async: alu_out=%h flags=%h pc=%0d state=%0d expected 00 00 0 %0d",
               alu_out, flags, dut.r_pc, dut.r_state, ST_FETCH);
    end
    rst = 1'b0;
    sb.push_back(model(8'h01, 8'h05, 8'h03, 8'h00, 8'h00));
    tick(); tick(); tick();
    exp_v = sb.pop_front();
    checks++;
    if (alu_out !== exp_v[15:8] || flags !== exp_v[7:0]) begin
      errors++;
      $display("FAIL rstexec_rerun: alu_out=%h flags=%h expected %h %h", alu_out, flags, exp_v[15:8], exp_v[7:0]);
    end
  endtask

  task automatic test_abort;
    prog = '{8'h01, 8'h05, 8'h03, 8'h02, 8'h09, 8'h04};
    load_prog();
    tick(); tick();
    ram_we = 1'b1;
    Data_w = 8'h01;
    tick();
    ram_we = 1'b0;
    checks++;
    if (dut.r_state !== ST_FETCH || dut.r_pc !== 6'd1 || alu_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_state: state=%0d pc=%0d alu_out=%h expected %0d 1 00",
               dut.r_state, dut.r_pc, alu_out, ST_FETCH);
    end
    sb.push_back(model(8'h05, 8'h03, 8'h02, 8'h00, 8'h00));
    tick(); tick(); tick();
    exp_v = sb.pop_front();
    checks++;
    if (alu_out !== exp_v[15:8] || flags !== exp_v[7:0]) begin
      errors++;
      $display("FAIL abort_restart: alu_out=%h flags=%h expected %h %h", alu_out, flags, exp_v[15:8], exp_v[7:0]);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] last;
    pulse_rst();
    ram_we = 1'b1;
    for (int i = 0; i < 65; i++) begin
      Data_w = (i == 64) ? 8'h5A : (i[7:0] ^ 8'hC3);
      tick();
    end
    ram_we = 1'b0;
    last = 8'd63 ^ 8'hC3;
    checks++;
    if (dut.r_pc !== 6'd1) begin
      errors++;
      $display("FAIL wrap_pc: pc=%0d expected 1", dut.r_pc);
    end
    checks++;
    if (dut.r_mem[0] !== 8'h5A || dut.r_mem[63] !== last) begin
      errors++;
      $display("FAIL wrap_mem: mem0=%h mem63=%h expected 5a %h", dut.r_mem[0], dut.r_mem[63], last);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_ops();
    test_back_to_back();
    test_halt();
    test_reset_exec();
    test_abort();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
